router_scheduler: RTL and testbench

ROUTER_SCHEDULER -- requirements
Module: router_scheduler

---
 rtl/router_scheduler.sv | 138 +++++++++++++
 tb/tb_router_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/router_scheduler.sv
// Layer scheduler coordinating the weight router, input router and systolic array.
// Walks each weight tile through load, run/feed contexts and a clear step until the layer completes.
module router_scheduler #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CNT_WIDTH-1:0] i_num_wtiles,
  input  logic                 i_wr_loaded,
  input  logic                 i_ir_ready,
  input  logic                 i_ir_context_done,
  input  logic                 i_ir_done,
  input  logic                 i_sa_ready,
  output logic                 o_ir_en,
  output logic                 o_ir_reg_clear,
  output logic                 o_ir_pop_en,
  output logic                 o_wr_load,
  output logic                 o_wr_reuse,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_wtile_idx,
  output logic [CNT_WIDTH-1:0] o_ctx_count,
  output logic [2:0]           o_state
);

  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("ADDR_WIDTH must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_RUN   = 3'd2,
    S_FEED  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [CNT_WIDTH-1:0] wtile_q, wtile_d;
  logic [CNT_WIDTH-1:0] ctx_q, ctx_d;
  logic                 wr_load_q, wr_load_d;
  logic                 wr_reuse_q, wr_reuse_d;
  logic                 reg_clear_q, reg_clear_d;
  logic                 done_q, done_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      wtile_q     <= '0;
      ctx_q       <= '0;
      wr_load_q   <= 1'b0;
      wr_reuse_q  <= 1'b0;
      reg_clear_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      wtile_q     <= wtile_d;
      ctx_q       <= ctx_d;
      wr_load_q   <= wr_load_d;
      wr_reuse_q  <= wr_reuse_d;
      reg_clear_q <= reg_clear_d;
      done_q      <= done_d;
    end
  end

  // Pulse outputs are set on the transition so they appear in the first cycle of the target state.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    wtile_d     = wtile_q;
    ctx_d       = ctx_q;
    wr_load_d   = 1'b0;
    wr_reuse_d  = 1'b0;
    reg_clear_d = 1'b0;
    done_d      = 1'b0;
    if (state_q != S_IDLE && i_abort) begin
      state_d     = S_IDLE;
      reg_clear_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            num_d     = (i_num_wtiles == '0) ? CNT_WIDTH'(1) : i_num_wtiles;
            wtile_d   = '0;
            ctx_d     = '0;
            wr_load_d = 1'b1;
            state_d   = S_WLOAD;
          end
        end
        S_WLOAD: if (i_wr_loaded) state_d = S_RUN;
        S_RUN:   if (i_ir_ready) state_d = S_FEED;
        S_FEED: begin
          // End of pass outranks a coincident context boundary.
          if (i_ir_done) begin
            state_d     = S_NEXT;
            reg_clear_d = 1'b1;
          end else if (i_ir_context_done) begin
            ctx_d      = ctx_q + CNT_WIDTH'(1);
            wr_reuse_d = 1'b1;
            state_d    = S_RUN;
          end
        end
        S_NEXT: begin
          if (wtile_q == num_q - CNT_WIDTH'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            wtile_d   = wtile_q + CNT_WIDTH'(1);
            ctx_d     = '0;
            wr_load_d = 1'b1;
            state_d   = S_WLOAD;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_ir_en        = (state_q == S_RUN) || (state_q == S_FEED);
  assign o_ir_pop_en    = (state_q == S_FEED) && i_sa_ready && !i_ir_done;
  assign o_ir_reg_clear = reg_clear_q;
  assign o_wr_load      = wr_load_q;
  assign o_wr_reuse     = wr_reuse_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = done_q;
  assign o_wtile_idx    = wtile_q;
  assign o_ctx_count    = ctx_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_router_scheduler.sv
// Directed self-checking bench for router_scheduler.
module tb_router_scheduler;
  localparam int CW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start, i_abort, i_wr_loaded, i_ir_ready;
  logic          i_ir_context_done, i_ir_done, i_sa_ready;
  logic [CW-1:0] i_num_wtiles;
  logic          o_ir_en, o_ir_reg_clear, o_ir_pop_en, o_wr_load, o_wr_reuse, o_busy, o_done;
  logic [CW-1:0] o_wtile_idx, o_ctx_count;
  logic [2:0]    o_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_load, n_reuse, n_clear, n_done;

  router_scheduler #(.ADDR_WIDTH(8), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_num_wtiles(i_num_wtiles), .i_wr_loaded(i_wr_loaded), .i_ir_ready(i_ir_ready),
    .i_ir_context_done(i_ir_context_done), .i_ir_done(i_ir_done), .i_sa_ready(i_sa_ready),
    .o_ir_en(o_ir_en), .o_ir_reg_clear(o_ir_reg_clear), .o_ir_pop_en(o_ir_pop_en),
    .o_wr_load(o_wr_load), .o_wr_reuse(o_wr_reuse), .o_busy(o_busy), .o_done(o_done),
    .o_wtile_idx(o_wtile_idx), .o_ctx_count(o_ctx_count), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {6'd0, o_ir_en, o_ir_reg_clear, o_ir_pop_en, o_wr_load, o_wr_reuse, o_busy,
            o_done, o_wtile_idx, o_ctx_count, o_state};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_wr_load)      n_load++;
    if (o_wr_reuse)     n_reuse++;
    if (o_ir_reg_clear) n_clear++;
    if (o_done)         n_done++;
  endtask

  task automatic clr_counts();
    n_load = 0; n_reuse = 0; n_clear = 0; n_done = 0;
  endtask

  task automatic start(input logic [CW-1:0] n);
    i_num_wtiles = n; i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic load();
    i_wr_loaded = 1'b1; tick(); i_wr_loaded = 1'b0;
  endtask

  task automatic to_feed();
    i_ir_ready = 1'b1; tick(); i_ir_ready = 1'b0;
  endtask

  task automatic ctx();
    i_ir_context_done = 1'b1; tick(); i_ir_context_done = 1'b0;
  endtask

  task automatic fin();
    i_ir_done = 1'b1; tick(); i_ir_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_wr_loaded = 1'b0; i_ir_ready = 1'b0;
    i_ir_context_done = 1'b0; i_ir_done = 1'b0; i_sa_ready = 1'b1; i_num_wtiles = '0;
    clr_counts();
    #8;
    check("reset_outs", all_outs(), 32'd0);
    #4 i_rst = 1'b0;
    tick();
    check("idle_after_reset", {29'd0, o_state}, 32'd0);

    // one tile, two contexts; start during DONE must be ignored
    clr_counts();
    start(8'd1);
    check("s1_wload", {29'd0, o_state}, 32'd1);
    check("s1_wr_load", {31'd0, o_wr_load}, 32'd1);
    check("s1_ir_en_wload", {31'd0, o_ir_en}, 32'd0);
    tick();
    check("s1_wait_loaded", {29'd0, o_state}, 32'd1);
    load();
    check("s1_run", {29'd0, o_state}, 32'd2);
    check("s1_ir_en_run", {31'd0, o_ir_en}, 32'd1);
    to_feed();
    check("s1_feed", {29'd0, o_state}, 32'd3);
    check("s1_pop", {31'd0, o_ir_pop_en}, 32'd1);
    ctx();
    check("s1_ctx1", {24'd0, o_ctx_count}, 32'd1);
    check("s1_reuse", {31'd0, o_wr_reuse}, 32'd1);
    to_feed(); ctx(); to_feed(); fin();
    check("s1_next", {29'd0, o_state}, 32'd4);
    check("s1_next_clear", {30'd0, o_ir_reg_clear, o_ir_en}, 32'd2);
    tick();
    check("s1_done", {28'd0, o_state, o_done}, 32'd11);
    i_start = 1'b1; tick(); i_start = 1'b0;
    check("s1_idle", {29'd0, o_state}, 32'd0);
    tick();
    check("s1_start_in_done_ignored", {29'd0, o_state}, 32'd0);
    check("s1_ctx_final", {24'd0, o_ctx_count}, 32'd2);
    check("s1_counts", {n_load[7:0], n_reuse[7:0], n_clear[7:0], n_done[7:0]}, 32'h01020101);

    // three tiles, one context each
    clr_counts();
    start(8'd3);
    for (int t = 0; t < 3; t++) begin
      check("s2_wload", {29'd0, o_state}, 32'd1);
      check("s2_wtile", {24'd0, o_wtile_idx}, 32'(t));
      check("s2_ctx_clear", {24'd0, o_ctx_count}, 32'd0);
      load(); to_feed(); ctx(); to_feed(); fin();
      check("s2_next", {29'd0, o_state}, 32'd4);
      tick();
    end
    check("s2_done", {28'd0, o_state, o_done}, 32'd11);
    tick();
    check("s2_idle", {29'd0, o_state}, 32'd0);
    check("s2_counts", {n_load[7:0], n_reuse[7:0], n_clear[7:0], n_done[7:0]}, 32'h03030301);

    // pop follows sa_ready; ir_done beats context_done
    clr_counts();
    start(8'd1); load(); to_feed(); ctx(); to_feed();
    i_sa_ready = 1'b1; #1 check("s3_pop_a", {31'd0, o_ir_pop_en}, 32'd1);
    i_sa_ready = 1'b0; #1 check("s3_pop_b", {31'd0, o_ir_pop_en}, 32'd0);
    i_sa_ready = 1'b1; #1 check("s3_pop_c", {31'd0, o_ir_pop_en}, 32'd1);
    i_ir_done = 1'b1;  #1 check("s3_pop_done", {31'd0, o_ir_pop_en}, 32'd0);
    i_ir_context_done = 1'b1;
    tick();
    i_ir_done = 1'b0; i_ir_context_done = 1'b0;
    check("s3_next", {29'd0, o_state}, 32'd4);
    check("s3_ctx_kept", {24'd0, o_ctx_count}, 32'd1);
    check("s3_no_reuse", {31'd0, o_wr_reuse}, 32'd0);
    tick(); tick();
    check("s3_reuse_count", n_reuse, 32'd1);

    // abort in FEED
    clr_counts();
    start(8'd2); load(); to_feed();
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    check("s4_idle", {29'd0, o_state}, 32'd0);
    check("s4_clear_pulse", {29'd0, o_ir_reg_clear, o_ir_en, o_busy}, 32'd4);
    tick();
    check("s4_clear_gone", {31'd0, o_ir_reg_clear}, 32'd0);
    check("s4_counts", {n_clear[7:0], n_done[7:0]}, 32'h0100);

    // zero tiles behaves as one; reset during WLOAD
    clr_counts();
    start(8'd0); load(); to_feed(); fin();
    check("s5_next", {29'd0, o_state}, 32'd4);
    tick();
    check("s5_done", {28'd0, o_state, o_done}, 32'd11);
    tick();
    start(8'd1);
    check("s5_wload", {28'd0, o_state, o_wr_load}, 32'd3);
    i_rst = 1'b1;
    #1 check("s5_async_reset", all_outs(), 32'd0);
    i_rst = 1'b0;
    tick();
    check("s5_idle_after_rst", {29'd0, o_state}, 32'd0);
    start(8'd5);
    check("s5_fresh_start", {o_wtile_idx, o_ctx_count, 12'd0, o_state, o_wr_load}, 32'h00000003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
